// File: rtl/cmp_pkg.sv
// Shared definitions for the serial and parallel magnitude comparators.
//   cmp_state_e  : sequencer states of the bit-serial comparator.
//   rel_flags_t  : one-hot relation flags ordered {Ab, ab, aB} (GT, EQ, LT).
//   rel_of_bits  : relation between two single bits, in rel_flags_t form.
package cmp_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StCmp
  } cmp_state_e;

  // Flag bit positions inside rel_flags_t.
  localparam int unsigned FlagGt = 2;  // Ab
  localparam int unsigned FlagEq = 1;  // ab
  localparam int unsigned FlagLt = 0;  // aB

  typedef logic [2:0] rel_flags_t;

  localparam rel_flags_t RelNone = 3'b000;
  localparam rel_flags_t RelGt   = 3'b100;
  localparam rel_flags_t RelEq   = 3'b010;
  localparam rel_flags_t RelLt   = 3'b001;

  // Relation of the two current MSBs; for equal bits this yields RelEq, which is
  // only committed when the last bit pair has been reached.
  function automatic rel_flags_t rel_of_bits(input logic sa, input logic sb);
    rel_flags_t rel;
    if (sa == sb) begin
      rel = RelEq;
    end else if (sa) begin
      rel = RelGt;
    end else begin
      rel = RelLt;
    end
    return rel;
  endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// Request/result bundle of the bit-serial comparator.
//   start    : compare request (master -> slave), sampled only while busy=0
//   A, B     : N-bit unsigned operands, captured on the accepting edge
//   busy     : comparison in progress
//   done     : one-cycle pulse, result flags valid from this cycle
//   Ab/ab/aB : A>B / A==B / A<B result flags, held until the next accept
interface serial_comparator_if #(
  parameter int unsigned N = 4
) ();

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic         Ab;
  logic         ab;
  logic         aB;

  modport master (
    output start, A, B,
    input  busy, done, Ab, ab, aB
  );

  modport slave (
    input  start, A, B,
    output busy, done, Ab, ab, aB
  );

endinterface

// File: rtl/piso_shift_reg.sv
// N-bit parallel-in, serial-out shift register, MSB first.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears the register
//   load_i  : parallel load of data_i (has priority over shift_i)
//   shift_i : shift left by one, zero fill at the LSB
//   data_i  : parallel load value
//   msb_o   : current MSB of the register
module piso_shift_reg #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [N-1:0] data_i,
  output logic         msb_o
);

  logic [N-1:0] data_q;
  logic [N-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = {data_q[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_o = data_q[N-1];

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial, MSB-first unsigned magnitude comparator.
// Captures A and B on an accepted start, compares one bit pair per clock and
// stops at the first differing bit (or after the LSB when equal), then pulses
// done for one cycle with the Ab/ab/aB flags valid and held.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (slave side), see serial_comparator_if
module serial_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_comparator_if.slave   bus
);

  localparam int unsigned CntW = $clog2(N);

  cmp_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic             done_q;
  rel_flags_t       flags_q;

  logic sa;
  logic sb;
  logic accept;
  logic last_bit;
  logic finish;
  logic shift;

  assign accept   = (state_q == StIdle) && bus.start;
  assign last_bit = (cnt_q == '0);
  assign finish   = (state_q == StCmp) && ((sa != sb) || last_bit);
  // Shift only when the current bit pair did not settle the result.
  assign shift    = (state_q == StCmp) && !finish;

  piso_shift_reg #(
    .N (N)
  ) u_shift_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .shift_i (shift),
    .data_i  (bus.A),
    .msb_o   (sa)
  );

  piso_shift_reg #(
    .N (N)
  ) u_shift_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .shift_i (shift),
    .data_i  (bus.B),
    .msb_o   (sb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      flags_q <= RelNone;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StCmp;
            cnt_q   <= CntW'(N - 1);
            flags_q <= RelNone;
          end
        end
        StCmp: begin
          if (finish) begin
            // Differing MSBs give GT/LT; equal MSBs here means last bit, so EQ.
            flags_q <= rel_of_bits(sa, sb);
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = (state_q == StCmp);
  assign bus.done = done_q;
  assign bus.Ab   = flags_q[FlagGt];
  assign bus.ab   = flags_q[FlagEq];
  assign bus.aB   = flags_q[FlagLt];

endmodule

// File: tb/tb_serial_comparator.sv
// Directed and random checks of serial_comparator at N=4 and N=8.
module tb_serial_comparator;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  serial_comparator_if #(.N(4)) bus4 ();
  serial_comparator_if #(.N(8)) bus8 ();

  serial_comparator #(
    .N (4)
  ) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  serial_comparator #(
    .N (8)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Back-to-back vectors: operands, expected {Ab,ab,aB}, expected latency.
  localparam logic [3:0] B2bA [4] = '{4'b0101, 4'b1111, 4'b0001, 4'b1010};
  localparam logic [3:0] B2bB [4] = '{4'b0110, 4'b1111, 4'b0000, 4'b0010};
  localparam logic [2:0] B2bF [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  localparam int         B2bL [4] = '{3, 4, 4, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] flags4();
    return {bus4.Ab, bus4.ab, bus4.aB};
  endfunction

  function automatic logic [2:0] flags8();
    return {bus8.Ab, bus8.ab, bus8.aB};
  endfunction

  // One N=4 compare; optional poke drives a conflicting start while busy.
  task automatic cmp4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] exp_f,
                      input int exp_lat, input bit poke);
    int lat;
    bit seen;
    @(posedge clk); #1;
    bus4.start = 1'b1;
    bus4.A     = a;
    bus4.B     = b;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.A     = ~a;
    bus4.B     = ~b;
    check("busy_after_accept", 32'(bus4.busy), 32'd1);
    check("flags_cleared", 32'(flags4()), 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (poke && c == 0) begin
        bus4.start = 1'b1;
        bus4.A     = 4'h0;
        bus4.B     = 4'hF;
      end else begin
        bus4.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus4.done) begin
        seen = 1'b1;
        break;
      end
    end
    bus4.start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("flags", 32'(flags4()), 32'(exp_f));
    check("busy_at_done", 32'(bus4.busy), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus4.done), 32'd0);
    check("flags_hold", 32'(flags4()), 32'(exp_f));
  endtask

  task automatic cmp8(input logic [7:0] a, input logic [7:0] b);
    int lat;
    int exp_lat;
    bit seen;
    logic [2:0] exp_f;
    exp_f   = (a > b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
    exp_lat = 8;
    for (int i = 7; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        exp_lat = 8 - i;
        break;
      end
    end
    @(posedge clk); #1;
    bus8.start = 1'b1;
    bus8.A     = a;
    bus8.B     = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      lat++;
      if (bus8.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("n8_done_seen", 32'(seen), 32'd1);
    check("n8_latency", 32'(lat), 32'(exp_lat));
    check("n8_flags", 32'(flags8()), 32'(exp_f));
  endtask

  initial begin
    int  lat;
    bit  seen;
    bit  stray;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus4.start = 1'b0;
    bus4.A     = '0;
    bus4.B     = '0;
    bus8.start = 1'b0;
    bus8.A     = '0;
    bus8.B     = '0;

    #3;
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_done", 32'(bus4.done), 32'd0);
    check("rst_flags", 32'(flags4()), 32'd0);
    check("rst_n8_flags", 32'({bus8.busy, bus8.done, flags8()}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed N=4 vectors.
    cmp4(4'b1110, 4'b1110, 3'b010, 4, 1'b0);
    cmp4(4'b0011, 4'b0010, 3'b100, 4, 1'b0);
    cmp4(4'b1001, 4'b1100, 3'b001, 2, 1'b0);
    cmp4(4'b1000, 4'b0111, 3'b100, 1, 1'b0);
    // Start pulse while busy must not disturb the captured operands.
    cmp4(4'b0011, 4'b0010, 3'b100, 4, 1'b1);

    // Start held high: each done cycle accepts the next pair.
    @(posedge clk); #1;
    bus4.start = 1'b1;
    bus4.A     = B2bA[0];
    bus4.B     = B2bB[0];
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      bus4.A = 4'b0110;  // don't-care while busy, start still high
      bus4.B = 4'b1001;
      lat    = 0;
      seen   = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        lat++;
        if (bus4.done) begin
          seen = 1'b1;
          break;
        end
      end
      check("b2b_done_seen", 32'(seen), 32'd1);
      check("b2b_latency", 32'(lat), 32'(B2bL[j]));
      check("b2b_flags", 32'(flags4()), 32'(B2bF[j]));
      if (j < 3) begin
        bus4.A = B2bA[j+1];
        bus4.B = B2bB[j+1];
      end else begin
        bus4.start = 1'b0;
      end
      // The done edge accepts the next request (or idles on the last one).
      @(posedge clk); #1;
      check("b2b_busy_next", 32'(bus4.busy), (j < 3) ? 32'd1 : 32'd0);
      check("b2b_done_cleared", 32'(bus4.done), 32'd0);
    end

    // Reset asserted mid-way through an equal-operand compare.
    @(posedge clk); #1;
    bus4.start = 1'b1;
    bus4.A     = 4'b1110;
    bus4.B     = 4'b1110;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus4.busy), 32'd0);
    check("midrst_done", 32'(bus4.done), 32'd0);
    check("midrst_flags", 32'(flags4()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      stray = stray | bus4.done | bus4.busy;
    end
    check("midrst_no_done", 32'(stray), 32'd0);
    cmp4(4'b1000, 4'b0111, 3'b100, 1, 1'b0);

    // N=8 corner cases then random pairs against a behavioural reference.
    cmp8(8'h00, 8'h00);
    cmp8(8'hFF, 8'hFF);
    cmp8(8'h80, 8'h7F);
    cmp8(8'h00, 8'h01);
    for (int k = 0; k < 1000; k++) begin
      cmp8(8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
- Bit-serial, MSB-first magnitude comparator for unsigned operands A and B.
- Produces the same three relation flags as the team's parallel N-bit comparator: Ab (A>B), ab (A==B), aB (A<B).
- Captures both operands on a start handshake and compares one bit per clock.
- Terminates early at the first differing bit, then reports the result with a one-cycle done pulse.
- Used where N is wide enough that a single-cycle comparator is undesirable, and as a sequential cross-check of the parallel comparator.

Parameters:
- N, 4, operand width in bits; legal range 2..64.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- start  input  1  request to compare A and B; sampled only while busy=0.
- A  input  N  operand A; captured on the accepting edge only.
- B  input  N  operand B; captured on the accepting edge only.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse; result flags are valid from this cycle.
- Ab  output  1  A>B result flag.
- ab  output  1  A==B result flag.
- aB  output  1  A<B result flag.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, Ab=ab=aB=0, shift registers and bit counter cleared.
- States:
  - IDLE: busy=0.
  - CMP: busy=1.
- IDLE -> CMP:
  - Occurs on the edge where start=1 ("edge 0").
  - Load A and B into shift registers and set counter = N-1.
  - Clear Ab/ab/aB to 0. done is 0 in the following cycle.
- CMP, each edge k (k=1..N): compare the current MSBs of the shift registers, sa and sb.
  - sa != sb: set Ab=sa, aB=sb, ab=0, done=1, go to IDLE.
  - sa == sb and counter == 0: set ab=1, Ab=aB=0, done=1, go to IDLE.
  - Otherwise: shift both registers left by 1, decrement counter, stay in CMP.
- Latency:
  - First differing bit at index i: done is high in the cycle following edge N-i.
  - Equal operands: done is high in the cycle following edge N.
  - Minimum latency is 1 cycle (MSBs differ); maximum is N cycles.
- done is high for exactly one cycle, then cleared on the next edge.
- Ab/ab/aB hold their value until the next accepted start or reset. At most one flag is ever high.
- start while busy=1 is ignored: no effect on state, operands or flags. A and B are don't-care after capture.
- start=1 in the same cycle done=1: state is IDLE, so the request is accepted. The new comparison begins and the flags clear on that edge (back-to-back operation, no idle gap required).
- Reset asserted mid-comparison: immediate return to the reset values above. No done pulse; the partial result is discarded.
- Arithmetic: operands are unsigned. The counter is clog2(N) bits wide, and no wrap occurs because the counter is never decremented past 0.

Decomposition:
- Shared package (cmp_pkg):
  - State enum {IDLE, CMP}.
  - Localparam for the relation-flag encoding (GT/EQ/LT one-hot order Ab, ab, aB), shared with the parallel comparator bench.
- Sub-module piso_shift_reg (N-bit parallel-load, shift-left, MSB-out), instantiated twice, once each for A and B.
- FSM, counter and result registers live in the top module.

Test Plan:
- Reset, then A=4'b1110, B=4'b1110, start for 1 cycle -> busy=1 for 4 cycles; done in the cycle after edge 4; ab=1, Ab=aB=0.
- A=4'b0011, B=4'b0010 -> differs at bit 0; done after edge 4; Ab=1, ab=aB=0.
- A=4'b1001, B=4'b1100 -> differs at bit 2; done after edge 2; aB=1. Then A=4'b1000, B=4'b0111 -> done after edge 1; Ab=1.
- Start held high continuously with a new A/B each time done=1 -> each result is accepted back-to-back with no lost or duplicated done pulses. start pulses inserted while busy=1 with different A/B -> ignored; the result matches the originally captured operands.
- Assert rst_n=0 at edge 2 of an N-cycle equal-operand compare -> busy, done and all flags read 0 immediately. After release, a new start completes normally.
- N=8, random 1000 operand pairs -> flags match the parallel comparator reference; done latency equals 8 minus the index of the highest differing bit, or 8 when equal.
